// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame sequencer: FSM states, frame-size helpers, clog2.
package fft_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADMIT = 2'd1,
        S_GAP   = 2'd2
    } seq_state_t;

    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = int'(i) + 1;
        end
        return r;
    endfunction

    function automatic int unsigned fft_n(input int unsigned logn);
        return 32'd1 << logn;
    endfunction

    function automatic int unsigned fft_hn(input int unsigned logn);
        return fft_n(logn) >> 1;
    endfunction

endpackage

// File: rtl/fft_out_counter.sv
// Output-side bookkeeping: sample index within frame, frame_done pulse, inflight decrement strobe.
module fft_out_counter
    import fft_pkg::*;
#(
    parameter int logn = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fft_out_valid,
    input  logic            inflight_nz,
    output logic [logn-1:0] out_idx,
    output logic            frame_done,
    output logic            dec
);

    localparam int unsigned N = fft_n(logn);

    logic hit;

    // Output samples with nothing in flight are stray and must not advance the count.
    assign hit = fft_out_valid && inflight_nz;
    assign dec = hit && (out_idx == logn'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            if (hit) out_idx <= out_idx + 1'b1;
            frame_done <= dec;
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame admission/gap controller in front of an SDF FFT pipeline.
// Optional stall watchdog enabled by defining FFT_SEQ_TIMEOUT_EN.
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int FLOAT_PRECISION = 64,
    parameter int logn            = 8,
    parameter int GAP_CYCLES      = 129,
    parameter int MAX_INFLIGHT    = 2,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic                               src_valid,
    output logic                               src_ready,
    input  logic [FLOAT_PRECISION-1:0]         src_re,
    input  logic [FLOAT_PRECISION-1:0]         src_im,
    output logic                               fft_in_valid,
    output logic [FLOAT_PRECISION-1:0]         fft_di_re,
    output logic [FLOAT_PRECISION-1:0]         fft_di_im,
    input  logic                               fft_out_valid,
    output logic                               frame_done,
    output logic [logn-1:0]                    out_idx,
    output logic [clog2(MAX_INFLIGHT+1)-1:0]   inflight,
    output logic                               busy,
    output logic                               err_timeout
);

    localparam int unsigned N  = fft_n(logn);
    localparam int          IW = clog2(MAX_INFLIGHT + 1);
    localparam int          GW = (clog2(GAP_CYCLES) < 1) ? 1 : clog2(GAP_CYCLES);

    if (GAP_CYCLES == 0) begin : g_gap_chk
        $error("fft_frame_sequencer: GAP_CYCLES must be nonzero");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_tmo_chk
        $error("fft_frame_sequencer: TIMEOUT_CYCLES must be nonzero");
    end

    seq_state_t      state, state_nxt;
    logic [logn-1:0] in_cnt, in_cnt_nxt;
    logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
    logic            accept, inc, dec;

    always_comb begin
        state_nxt   = state;
        in_cnt_nxt  = in_cnt;
        gap_cnt_nxt = gap_cnt;
        inc         = 1'b0;
        src_ready   = 1'b0;
        case (state)
            S_IDLE:  src_ready = enable && (inflight < IW'(MAX_INFLIGHT));
            S_ADMIT: src_ready = 1'b1;
            default: src_ready = 1'b0;
        endcase
        // Held low throughout reset so every output reads 0 while rst_n is asserted.
        src_ready = src_ready && rst_n;
        accept    = src_valid && src_ready;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt  = S_ADMIT;
                    in_cnt_nxt = logn'(1);
                end
            end
            S_ADMIT: begin
                if (accept) begin
                    if (in_cnt == logn'(N - 1)) begin
                        state_nxt   = S_GAP;
                        gap_cnt_nxt = GW'(GAP_CYCLES - 1);
                        in_cnt_nxt  = '0;
                        inc         = 1'b1;
                    end else begin
                        in_cnt_nxt = in_cnt + 1'b1;
                    end
                end
            end
            default: begin
                if (gap_cnt == '0) state_nxt = S_IDLE;
                else               gap_cnt_nxt = gap_cnt - 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            in_cnt       <= '0;
            gap_cnt      <= '0;
            inflight     <= '0;
            fft_in_valid <= 1'b0;
            fft_di_re    <= '0;
            fft_di_im    <= '0;
        end else begin
            state        <= state_nxt;
            in_cnt       <= in_cnt_nxt;
            gap_cnt      <= gap_cnt_nxt;
            fft_in_valid <= accept;
            if (accept) begin
                fft_di_re <= src_re;
                fft_di_im <= src_im;
            end
            if (inc && !dec)      inflight <= inflight + 1'b1;
            else if (dec && !inc) inflight <= inflight - 1'b1;
        end
    end

    fft_out_counter #(.logn(logn)) u_out_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .fft_out_valid(fft_out_valid),
        .inflight_nz  (inflight != '0),
        .out_idx      (out_idx),
        .frame_done   (frame_done),
        .dec          (dec)
    );

    assign busy = (state != S_IDLE) || (inflight != '0);

`ifdef FFT_SEQ_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] stall_cnt;
    logic          err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else if (state == S_ADMIT && !accept) begin
            if (stall_cnt != TW'(TIMEOUT_CYCLES)) stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == TW'(TIMEOUT_CYCLES - 1)) err_q <= 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end

    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer at logn=3, GAP_CYCLES=5, MAX_INFLIGHT=2.
module tb_fft_frame_sequencer;

    localparam int W    = 16;
    localparam int LOGN = 3;
    localparam int NPT  = 8;
    localparam int GAP  = 5;
    localparam int MAXF = 2;
    localparam int TMO  = 16;

    logic         clk, rst_n, enable, src_valid, src_ready;
    logic [W-1:0] src_re, src_im, fft_di_re, fft_di_im;
    logic         fft_in_valid, fft_out_valid, frame_done, busy, err_timeout;
    logic [LOGN-1:0] out_idx;
    logic [1:0]   inflight;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] sb_re[$];
    logic [W-1:0] sb_im[$];
    logic         prev_acc;
    logic [W-1:0] last_re, last_im, exp_re, exp_im;

    fft_frame_sequencer #(
        .FLOAT_PRECISION(W),
        .logn           (LOGN),
        .GAP_CYCLES     (GAP),
        .MAX_INFLIGHT   (MAXF),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_re       (src_re),
        .src_im       (src_im),
        .fft_in_valid (fft_in_valid),
        .fft_di_re    (fft_di_re),
        .fft_di_im    (fft_di_im),
        .fft_out_valid(fft_out_valid),
        .frame_done   (frame_done),
        .out_idx      (out_idx),
        .inflight     (inflight),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forwarding scoreboard: accepted samples are queued and must reappear one cycle later.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_re.delete();
            sb_im.delete();
            prev_acc = 1'b0;
            last_re  = '0;
            last_im  = '0;
        end else begin
            n_tests++;
            if (fft_in_valid !== prev_acc) begin
                n_fail++;
                $display("FAIL fwd_valid: got %b expected %b", fft_in_valid, prev_acc);
            end
            if (fft_in_valid === 1'b1 && sb_re.size() != 0) begin
                exp_re = sb_re.pop_front();
                exp_im = sb_im.pop_front();
                n_tests++;
                if ({fft_di_re, fft_di_im} !== {exp_re, exp_im}) begin
                    n_fail++;
                    $display("FAIL fwd_data: got %h/%h expected %h/%h", fft_di_re, fft_di_im, exp_re, exp_im);
                end
                last_re = exp_re;
                last_im = exp_im;
            end else if (fft_in_valid !== 1'b1) begin
                n_tests++;
                if ({fft_di_re, fft_di_im} !== {last_re, last_im}) begin
                    n_fail++;
                    $display("FAIL fwd_hold: got %h/%h expected %h/%h", fft_di_re, fft_di_im, last_re, last_im);
                end
            end
            prev_acc = src_valid && src_ready;
            if (prev_acc) begin
                sb_re.push_back(src_re);
                sb_im.push_back(src_im);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic new_data;
        src_re = W'($urandom);
        src_im = W'($urandom);
    endtask

    task automatic drain_frame(input string name);
        fft_out_valid = 1'b1;
        repeat (NPT) tick();
        fft_out_valid = 1'b0;
        n_tests++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done: got %b expected 1", name, frame_done);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b1; src_valid = 1'b1; fft_out_valid = 1'b1;
        src_re = 16'h1234; src_im = 16'h5678;
        repeat (2) tick();
        n_tests++;
        if ({src_ready, fft_in_valid, frame_done, busy, err_timeout} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {src_ready, fft_in_valid, frame_done, busy, err_timeout});
        end
        n_tests++;
        if ({out_idx, inflight, fft_di_re, fft_di_im} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got idx=%0d infl=%0d re=%h im=%h expected all 0",
                     out_idx, inflight, fft_di_re, fft_di_im);
        end
        src_valid = 1'b0; fft_out_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({busy, src_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_release: got busy=%b ready=%b expected busy=0 ready=1", busy, src_ready);
        end
    endtask

    task automatic test_back_to_back;
        src_valid = 1'b1;
        for (int i = 0; i < NPT; i++) begin
            new_data();
            n_tests++;
            if (src_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1[%0d]: got %b expected 1", i, src_ready); end
            tick();
        end
        n_tests++;
        if (inflight !== 2'd1) begin n_fail++; $display("FAIL b2b_infl1: got %0d expected 1", inflight); end
        for (int g = 0; g < GAP; g++) begin
            n_tests++;
            if (src_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_gap[%0d]: got %b expected 0", g, src_ready); end
            tick();
        end
        for (int i = 0; i < NPT; i++) begin
            new_data();
            n_tests++;
            if (src_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2[%0d]: got %b expected 1", i, src_ready); end
            tick();
        end
        src_valid = 1'b0;
        n_tests++;
        if (inflight !== 2'd2) begin n_fail++; $display("FAIL b2b_infl2: got %0d expected 2", inflight); end
        repeat (GAP) tick();
    endtask

    task automatic test_inflight_limit;
        src_valid = 1'b1;
        new_data();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({src_ready, busy} !== 2'b01) begin
                n_fail++;
                $display("FAIL limit_block[%0d]: got ready=%b busy=%b expected ready=0 busy=1", i, src_ready, busy);
            end
            tick();
        end
        src_valid = 1'b0;
        fft_out_valid = 1'b1;
        for (int k = 0; k < NPT; k++) begin
            n_tests++;
            if ({out_idx, frame_done} !== {LOGN'(k), 1'b0}) begin
                n_fail++;
                $display("FAIL limit_idx[%0d]: got idx=%0d done=%b expected idx=%0d done=0", k, out_idx, frame_done, k);
            end
            tick();
        end
        fft_out_valid = 1'b0;
        n_tests++;
        if ({frame_done, inflight, src_ready} !== 4'b1_01_1) begin
            n_fail++;
            $display("FAIL limit_release: got done=%b infl=%0d ready=%b expected done=1 infl=1 ready=1",
                     frame_done, inflight, src_ready);
        end
        tick();
        n_tests++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL limit_pulse_width: got %b expected 0", frame_done); end
        drain_frame("limit_drain");
        n_tests++;
        if ({inflight, busy} !== 3'b00_0) begin
            n_fail++;
            $display("FAIL limit_empty: got infl=%0d busy=%b expected 0/0", inflight, busy);
        end
        tick();
    endtask

    task automatic test_ignored_out;
        fft_out_valid = 1'b1;
        repeat (3) begin
            tick();
            n_tests++;
            if ({out_idx, frame_done, inflight} !== '0) begin
                n_fail++;
                $display("FAIL ignored_out: got idx=%0d done=%b infl=%0d expected 0/0/0", out_idx, frame_done, inflight);
            end
        end
        fft_out_valid = 1'b0;
    endtask

    task automatic test_bubbly;
        for (int i = 0; i < 16; i++) begin
            src_valid = (i % 2 == 0);
            new_data();
            tick();
            n_tests++;
            if (inflight !== ((i >= 14) ? 2'd1 : 2'd0)) begin
                n_fail++;
                $display("FAIL bubbly_infl[%0d]: got %0d expected %0d", i, inflight, (i >= 14) ? 1 : 0);
            end
        end
        src_valid = 1'b0;
        repeat (GAP - 1) tick();
        drain_frame("bubbly_drain");
        tick();
    endtask

    task automatic test_simultaneous;
        src_valid = 1'b1;
        for (int i = 0; i < NPT; i++) begin new_data(); tick(); end
        src_valid = 1'b0;
        repeat (GAP) tick();
        src_valid = 1'b1;
        fft_out_valid = 1'b1;
        for (int i = 0; i < NPT; i++) begin new_data(); tick(); end
        src_valid = 1'b0;
        fft_out_valid = 1'b0;
        n_tests++;
        if ({inflight, frame_done} !== 3'b01_1) begin
            n_fail++;
            $display("FAIL simul_incdec: got infl=%0d done=%b expected infl=1 done=1", inflight, frame_done);
        end
        repeat (GAP) tick();
        drain_frame("simul_drain");
        tick();
    endtask

    task automatic test_reset_midframe;
        src_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin new_data(); tick(); end
        src_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({fft_in_valid, busy, src_ready, inflight, fft_di_re, fft_di_im} !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: got v=%b busy=%b rdy=%b infl=%0d re=%h im=%h expected all 0",
                     fft_in_valid, busy, src_ready, inflight, fft_di_re, fft_di_im);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({busy, src_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_idle: got busy=%b ready=%b expected busy=0 ready=1", busy, src_ready);
        end
        src_valid = 1'b1;
        for (int i = 0; i < NPT - 1; i++) begin new_data(); tick(); end
        n_tests++;
        if (inflight !== 2'd0) begin n_fail++; $display("FAIL midrst_count7: got %0d expected 0", inflight); end
        new_data();
        tick();
        src_valid = 1'b0;
        n_tests++;
        if (inflight !== 2'd1) begin n_fail++; $display("FAIL midrst_count8: got %0d expected 1", inflight); end
        repeat (GAP) tick();
        drain_frame("midrst_drain");
        tick();
    endtask

`ifdef FFT_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        src_valid = 1'b1;
        new_data();
        tick();
        src_valid = 1'b0;
        for (int s = 1; s <= TMO; s++) begin
            tick();
            n_tests++;
            if (err_timeout !== ((s >= TMO) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL tmo_stall[%0d]: got %b expected %b", s, err_timeout, (s >= TMO) ? 1'b1 : 1'b0);
            end
        end
        src_valid = 1'b1;
        for (int i = 0; i < NPT - 1; i++) begin new_data(); tick(); end
        src_valid = 1'b0;
        repeat (GAP) tick();
        n_tests++;
        if ({err_timeout, inflight} !== 3'b1_01) begin
            n_fail++;
            $display("FAIL tmo_sticky: got err=%b infl=%0d expected err=1 infl=1", err_timeout, inflight);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b expected 0", err_timeout); end
    endtask
`else
    task automatic test_timeout;
        n_tests++;
        if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_tied: got %b expected 0", err_timeout); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; enable = 1'b0; src_valid = 1'b0; fft_out_valid = 1'b0;
        src_re = '0; src_im = '0;
        test_reset();
        test_back_to_back();
        test_inflight_limit();
        test_ignored_out();
        test_bubbly();
        test_simultaneous();
        test_reset_midframe();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
